// File: rtl/fpdiv_pkg.sv
// Shared types and select encodings for the fpdiv control sequencer.
package fpdiv_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      IA_N = 3'd1,
      IA_D = 3'd2,
      IT_N = 3'd3,
      IT_D = 3'd4,
      REM  = 3'd5,
      DONE = 3'd6
   } state_t;

   localparam logic [1:0] M4_IA_N = 2'b00;
   localparam logic [1:0] M4_IA_D = 2'b01;
   localparam logic [1:0] M4_C_N  = 2'b10;
   localparam logic [1:0] M4_C_D  = 2'b11;

   localparam logic [1:0] M3_IA   = 2'b00;
   localparam logic [1:0] M3_C    = 2'b01;
   localparam logic [1:0] M3_REM  = 2'b10;

   localparam int ITER_W = 4;

endpackage

// File: rtl/fpdiv_ctrl_if.sv
// Handshake and datapath-control bundle between FP top, sequencer and datapath.
interface fpdiv_ctrl_if;

   logic       start;
   logic       flush;
   logic [1:0] sel_mux4;
   logic [1:0] sel_mux3;
   logic       en_a;
   logic       en_b;
   logic       en_rem;
   logic       busy;
   logic       done;
   logic [3:0] iter;

   modport master (
      output start, flush,
      input  sel_mux4, sel_mux3, en_a, en_b, en_rem,
      input  busy, done, iter
   );

   modport slave (
      input  start, flush,
      output sel_mux4, sel_mux3, en_a, en_b, en_rem,
      output busy, done, iter
   );

endinterface

// File: rtl/fpdiv_iter_cnt.sv
// Refinement-pair counter: clear, load-to-one, increment, terminal flag.
module fpdiv_iter_cnt #(
   parameter int MAX = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_clr,
   input  logic       i_load,
   input  logic       i_inc,
   output logic [3:0] o_cnt,
   output logic       o_tc
);

   logic [3:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= 4'd0;
      end else if (i_clr) begin
         r_cnt <= 4'd0;
      end else if (i_load) begin
         r_cnt <= 4'd1;
      end else if (i_inc) begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == 4'(MAX));

endmodule

// File: rtl/fpdiv_ctrl.sv
// Moore sequencer for the Goldschmidt divider: seed, refinement pairs, remainder.
module fpdiv_ctrl
   import fpdiv_pkg::*;
#(
   parameter int ITERATIONS = 6
) (
   input  logic         clk,
   input  logic         reset,
   fpdiv_ctrl_if.slave  bus
);

   if (ITERATIONS < 1 || ITERATIONS > 15) begin : g_bad_iter
      $fatal(1, "fpdiv_ctrl: ITERATIONS must be 1..15");
   end

   state_t     r_state;
   state_t     w_next;
   logic       w_clr;
   logic       w_load;
   logic       w_inc;
   logic [3:0] w_cnt;
   logic       w_tc;

   fpdiv_iter_cnt #(
      .MAX    (ITERATIONS)
   ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (w_clr),
      .i_load (w_load),
      .i_inc  (w_inc),
      .o_cnt  (w_cnt),
      .o_tc   (w_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // flush wins over everything but reset; it is a no-op while idle
   always_comb begin
      w_next = r_state;
      w_clr  = 1'b0;
      w_load = 1'b0;
      w_inc  = 1'b0;
      if (bus.flush && r_state != IDLE) begin
         w_next = IDLE;
         w_clr  = 1'b1;
      end else begin
         unique case (r_state)
            IDLE: if (bus.start) w_next = IA_N;
            IA_N: w_next = IA_D;
            IA_D: begin
               w_next = IT_N;
               w_load = 1'b1;
            end
            IT_N: w_next = IT_D;
            IT_D: begin
               if (w_tc) begin
                  w_next = REM;
                  w_clr  = 1'b1;
               end else begin
                  w_next = IT_N;
                  w_inc  = 1'b1;
               end
            end
            REM:  w_next = DONE;
            DONE: w_next = bus.start ? IA_N : IDLE;
            default: begin
               w_next = IDLE;
               w_clr  = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      bus.sel_mux4 = M4_IA_N;
      bus.sel_mux3 = M3_IA;
      bus.en_a     = 1'b0;
      bus.en_b     = 1'b0;
      bus.en_rem   = 1'b0;
      bus.busy     = 1'b1;
      bus.done     = 1'b0;
      bus.iter     = 4'd0;
      unique case (r_state)
         IA_N: bus.en_a = 1'b1;
         IA_D: begin
            bus.sel_mux4 = M4_IA_D;
            bus.en_b     = 1'b1;
         end
         IT_N: begin
            bus.sel_mux4 = M4_C_N;
            bus.sel_mux3 = M3_C;
            bus.en_a     = 1'b1;
            bus.iter     = w_cnt;
         end
         IT_D: begin
            bus.sel_mux4 = M4_C_D;
            bus.sel_mux3 = M3_C;
            bus.en_b     = 1'b1;
            bus.iter     = w_cnt;
         end
         REM: begin
            bus.sel_mux4 = M4_IA_D;
            bus.sel_mux3 = M3_REM;
            bus.en_rem   = 1'b1;
         end
         DONE: begin
            bus.busy = 1'b0;
            bus.done = 1'b1;
         end
         default: bus.busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Scoreboard bench for fpdiv_ctrl: expected per-cycle control vectors are queued at start.
module tb_fpdiv_ctrl;

   localparam int N0 = 6;
   localparam int N1 = 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   fpdiv_ctrl_if b0();
   fpdiv_ctrl_if b1();

   fpdiv_ctrl #(.ITERATIONS(N0)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (b0)
   );

   fpdiv_ctrl #(.ITERATIONS(N1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (b1)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [12:0] sb_q[$];

   // {sel_mux4, sel_mux3, en_a en_b en_rem, busy, done, iter}
   function automatic logic [12:0] vec(input logic [1:0] m4, input logic [1:0] m3,
                                       input logic [2:0] en, input logic bz,
                                       input logic dn, input logic [3:0] it);
      return {m4, m3, en, bz, dn, it};
   endfunction

   function automatic logic [12:0] idle_v();
      return vec(2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 4'd0);
   endfunction

   // push the first k cycles of one operation with n refinement pairs
   function automatic void push_op(input int n, input int k);
      logic [12:0] t[$];
      t.push_back(vec(2'b00, 2'b00, 3'b100, 1'b1, 1'b0, 4'd0));
      t.push_back(vec(2'b01, 2'b00, 3'b010, 1'b1, 1'b0, 4'd0));
      for (int i = 1; i <= n; i++) begin
         t.push_back(vec(2'b10, 2'b01, 3'b100, 1'b1, 1'b0, 4'(i)));
         t.push_back(vec(2'b11, 2'b01, 3'b010, 1'b1, 1'b0, 4'(i)));
      end
      t.push_back(vec(2'b01, 2'b10, 3'b001, 1'b1, 1'b0, 4'd0));
      t.push_back(vec(2'b00, 2'b00, 3'b000, 1'b0, 1'b1, 4'd0));
      for (int i = 0; i < k && i < t.size(); i++) sb_q.push_back(t[i]);
   endfunction

   function automatic logic [12:0] obs0();
      return {b0.sel_mux4, b0.sel_mux3, b0.en_a, b0.en_b, b0.en_rem,
              b0.busy, b0.done, b0.iter};
   endfunction

   function automatic logic [12:0] obs1();
      return {b1.sel_mux4, b1.sel_mux3, b1.en_a, b1.en_b, b1.en_rem,
              b1.busy, b1.done, b1.iter};
   endfunction

   task automatic test_reset();
      logic [12:0] o;
      #12;
      o = obs0();
      n_cmp++;
      if (o !== idle_v()) begin
         n_bad++;
         $display("FAIL reset_dut0 got=%h exp=%h", o, idle_v());
      end
      o = obs1();
      n_cmp++;
      if (o !== idle_v()) begin
         n_bad++;
         $display("FAIL reset_dut1 got=%h exp=%h", o, idle_v());
      end
      #1 reset = 1'b0;
      @(negedge clk);
      o = obs0();
      n_cmp++;
      if (o !== idle_v()) begin
         n_bad++;
         $display("FAIL reset_release got=%h exp=%h", o, idle_v());
      end
   endtask

   task automatic test_single(input string tag);
      logic [12:0] e;
      logic [12:0] o;
      int i = 0;
      b0.start = 1'b1;
      @(posedge clk);
      #1 b0.start = 1'b0;
      push_op(N0, 100);
      sb_q.push_back(idle_v());
      while (sb_q.size() > 0) begin
         @(negedge clk);
         e = sb_q.pop_front();
         o = obs0();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, i + 1, o, e);
         end
         i++;
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] e;
      logic [12:0] o;
      int i = 0;
      int d1 = -1;
      int d2 = -1;
      b0.start = 1'b1;
      @(posedge clk);
      #1;
      push_op(N0, 100);
      push_op(N0, 100);
      sb_q.push_back(idle_v());
      while (sb_q.size() > 0) begin
         @(negedge clk);
         e = sb_q.pop_front();
         o = obs0();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL b2b cyc=%0d got=%h exp=%h", i + 1, o, e);
         end
         if (b0.done === 1'b1) begin
            if (d1 < 0) d1 = i;
            else if (d2 < 0) d2 = i;
         end
         if (i == 20) b0.start = 1'b0;
         i++;
      end
      n_cmp++;
      if (d2 - d1 !== 16) begin
         n_bad++;
         $display("FAIL b2b_done_gap got=%0d exp=16", d2 - d1);
      end
   endtask

   task automatic test_ignore_start();
      logic [12:0] e;
      logic [12:0] o;
      int i = 0;
      b0.start = 1'b1;
      @(posedge clk);
      #1 b0.start = 1'b0;
      push_op(N0, 100);
      sb_q.push_back(idle_v());
      sb_q.push_back(idle_v());
      while (sb_q.size() > 0) begin
         @(negedge clk);
         e = sb_q.pop_front();
         o = obs0();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL ignore cyc=%0d got=%h exp=%h", i + 1, o, e);
         end
         if (i == 7) b0.start = 1'b1;
         if (i == 8) b0.start = 1'b0;
         i++;
      end
   endtask

   task automatic test_flush();
      logic [12:0] e;
      logic [12:0] o;
      int i = 0;
      b0.start = 1'b1;
      @(posedge clk);
      #1 b0.start = 1'b0;
      push_op(N0, 9);
      sb_q.push_back(idle_v());
      sb_q.push_back(idle_v());
      while (sb_q.size() > 0) begin
         @(negedge clk);
         e = sb_q.pop_front();
         o = obs0();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL flush cyc=%0d got=%h exp=%h", i + 1, o, e);
         end
         if (i == 8) b0.flush = 1'b1;
         if (i == 9) b0.flush = 1'b0;
         i++;
      end
   endtask

   task automatic test_flush_done();
      logic [12:0] e;
      logic [12:0] o;
      int i = 0;
      b0.start = 1'b1;
      @(posedge clk);
      #1;
      push_op(N0, 100);
      sb_q.push_back(idle_v());
      sb_q.push_back(idle_v());
      while (sb_q.size() > 0) begin
         @(negedge clk);
         e = sb_q.pop_front();
         o = obs0();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL flush_done cyc=%0d got=%h exp=%h", i + 1, o, e);
         end
         if (i == 15) b0.flush = 1'b1;
         if (i == 16) begin
            b0.flush = 1'b0;
            b0.start = 1'b0;
         end
         i++;
      end
   endtask

   task automatic test_async_reset();
      logic [12:0] e;
      logic [12:0] o;
      int i = 0;
      b0.start = 1'b1;
      @(posedge clk);
      #1 b0.start = 1'b0;
      push_op(N0, 15);
      while (sb_q.size() > 0) begin
         @(negedge clk);
         e = sb_q.pop_front();
         o = obs0();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL areset_pre cyc=%0d got=%h exp=%h", i + 1, o, e);
         end
         i++;
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (b0.en_rem !== 1'b0) begin
         n_bad++;
         $display("FAIL areset_en_rem got=%b exp=0", b0.en_rem);
      end
      o = obs0();
      n_cmp++;
      if (o !== idle_v()) begin
         n_bad++;
         $display("FAIL areset_outs got=%h exp=%h", o, idle_v());
      end
      #1 reset = 1'b0;
      @(negedge clk);
      o = obs0();
      n_cmp++;
      if (o !== idle_v()) begin
         n_bad++;
         $display("FAIL areset_idle got=%h exp=%h", o, idle_v());
      end
   endtask

   task automatic test_iter1();
      logic [12:0] e;
      logic [12:0] o;
      int i = 0;
      b1.start = 1'b1;
      @(posedge clk);
      #1 b1.start = 1'b0;
      push_op(N1, 100);
      sb_q.push_back(idle_v());
      while (sb_q.size() > 0) begin
         @(negedge clk);
         e = sb_q.pop_front();
         o = obs1();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL iter1 cyc=%0d got=%h exp=%h", i + 1, o, e);
         end
         i++;
      end
   endtask

   initial begin
      b0.start = 1'b0;
      b0.flush = 1'b0;
      b1.start = 1'b0;
      b1.flush = 1'b0;
      test_reset();
      test_single("single");
      test_back_to_back();
      test_ignore_start();
      test_flush();
      test_single("after_flush");
      test_flush_done();
      test_async_reset();
      test_single("after_reset");
      test_iter1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
